// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory port: one byte/half/word request
// per handshake. Define MISALIGN_EN to allow unaligned accesses split over two words.
module dmem_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  we,
    input  logic [31:0] drdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

`ifdef MISALIGN_EN
    localparam logic ALIGN_CHK = 1'b0;
`else
    localparam logic ALIGN_CHK = 1'b1;
`endif

    // Byte-lane enables across the two-word window starting at the aligned address.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] lane_bytes(input logic [7:0] m);
        logic [63:0] b;
        for (int i = 0; i < 8; i++) begin
            b[8*i +: 8] = {8{m[i]}};
        end
        return b;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                                input logic uns);
        case (size)
            2'd0:    return {{24{~uns & raw[7]}}, raw[7:0]};
            2'd1:    return {{16{~uns & raw[15]}}, raw[15:0]};
            2'd2:    return raw;
            default: return 32'h0000_0000;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_we;
    logic        r_uns;
    logic        r_err;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic [31:0] r_hi;

    logic        w_req_err;
    logic [1:0]  w_off;
    logic [7:0]  w_mask8;
    logic [63:0] w_wd64;
    logic        w_cross;
    logic [31:0] w_word;
    logic [31:0] w_load_raw;

    assign w_off      = r_addr[1:0];
    assign w_mask8    = lane_mask(r_size, w_off);
    assign w_wd64     = ({32'h0000_0000, r_wdata} << {w_off, 3'b000}) & lane_bytes(w_mask8);
    assign w_cross    = |w_mask8[7:4];
    assign w_word     = {r_addr[31:2], 2'b00};
    assign w_load_raw = 32'({r_hi, r_lo} >> {w_off, 3'b000});

    // Request legality: reserved size always fails; alignment only checked without MISALIGN_EN.
    always_comb begin
        w_req_err = 1'b0;
        case (req_size)
            2'd0:    w_req_err = 1'b0;
            2'd1:    w_req_err = ALIGN_CHK & req_addr[0];
            2'd2:    w_req_err = ALIGN_CHK & (|req_addr[1:0]);
            default: w_req_err = 1'b1;
        endcase
    end

    // State register, request capture and load-data buffers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= 32'h0000_0000;
            r_size  <= 2'b00;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= 32'h0000_0000;
            r_lo    <= 32'h0000_0000;
            r_hi    <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            if (req_valid && req_ready) begin
                r_addr  <= req_addr;
                r_size  <= req_size;
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_err   <= w_req_err;
                r_wdata <= req_wdata;
            end
            if (r_state == ST_ACC0) begin
                r_lo <= drdata;
            end
            if (r_state == ST_ACC1) begin
                r_hi <= drdata;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = w_req_err ? ST_RESP : ST_ACC0;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ACC0: begin
                if (w_cross) begin
                    w_next = ST_ACC1;
                end else begin
                    w_next = ST_RESP;
                end
            end
            ST_ACC1: w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode; everything is held at zero while rst_n is low so no lane is written.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0000_0000;
        daddr     = 32'h0000_0000;
        dwdata    = 32'h0000_0000;
        we        = 4'b0000;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: req_ready = 1'b1;
                ST_ACC0: begin
                    daddr = w_word;
                    if (r_we) begin
                        we     = w_mask8[3:0];
                        dwdata = w_wd64[31:0];
                    end else begin
                        we     = 4'b0000;
                        dwdata = 32'h0000_0000;
                    end
                end
                ST_ACC1: begin
                    daddr = w_word + 32'd4;
                    if (r_we) begin
                        we     = w_mask8[7:4];
                        dwdata = w_wd64[63:32];
                    end else begin
                        we     = 4'b0000;
                        dwdata = 32'h0000_0000;
                    end
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    rsp_err   = r_err;
                    if (!r_we && !r_err) begin
                        rsp_rdata = load_extend(w_load_raw, r_size, r_uns);
                    end else begin
                        rsp_rdata = 32'h0000_0000;
                    end
                end
                default: req_ready = 1'b0;
            endcase
        end else begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed loads/stores against a byte-array memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic [31:0] drdata;

    dmem_lsu dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .daddr(daddr), .dwdata(dwdata),
        .we(we), .drdata(drdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } wr_t;

    rsp_t rsq[$];
    wr_t  wrq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] mem [0:255];

    assign drdata = {mem[{daddr[7:2], 2'b11}], mem[{daddr[7:2], 2'b10}],
                     mem[{daddr[7:2], 2'b01}], mem[{daddr[7:2], 2'b00}]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[{daddr[7:2], 2'(i)}] <= dwdata[8*i +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rsq.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = rsq.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_latency", cyc - e.acc_cyc, e.lat);
            end
        end
    end

    // Write monitor: every cycle with lane enables must match the next expected write.
    always @(negedge clk) begin
        if (we != 4'b0000) begin
            if (wrq.size() == 0) begin
                check("unexpected_write", {28'd0, we}, 32'd0);
            end else begin
                wr_t w;
                w = wrq.pop_front();
                check("wr_daddr", daddr, w.addr);
                check("wr_we", {28'd0, we}, {28'd0, w.we});
                check("wr_dwdata", dwdata, w.data);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_e, input int lat,
                         input logic [31:0] exp_daddr0);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        for (int t = 0; t < 20 && !got; t++) begin
            if (req_ready) begin
                got = 1'b1;
                rsq.push_back('{exp_rd, exp_e, cyc, lat});
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF;
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            check("first_cycle_daddr", daddr, exp_daddr0);
        end
        for (int t = 0; t < 10 && rsq.size() != 0; t++) @(negedge clk);
        if (rsq.size() != 0) begin
            check("rsp_timeout", rsq.size(), 32'd0);
            rsq.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h55; mem[8'h11] = 8'h66; mem[8'h12] = 8'h77; mem[8'h13] = 8'h88;
        mem[8'h14] = 8'h99; mem[8'h15] = 8'hAA; mem[8'h16] = 8'hBB; mem[8'h17] = 8'hCC;
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h23] = 8'h44;

        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_we", {28'd0, we}, 32'd0);
        check("rst_daddr", daddr, 32'd0);
        check("rst_dwdata", dwdata, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;

        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 32'h10);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0000_0088, 1'b0, 2, 32'h10);
        issue(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 32'hFFFF_CCBB, 1'b0, 2, 32'h14);
        issue(1'b0, 2'd1, 1'b1, 32'h14, 32'h0, 32'h0000_AA99, 1'b0, 2, 32'h14);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8877_6655, 1'b0, 2, 32'h10);

        wrq.push_back('{32'h20, 4'b0010, 32'h0000_AB00});
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FFAB, 32'h0, 1'b0, 2, 32'h20);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h4433_AB11, 1'b0, 2, 32'h20);
        wrq.push_back('{32'h20, 4'b1100, 32'hBEEF_0000});
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h5555_BEEF, 32'h0, 1'b0, 2, 32'h20);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hBEEF_AB11, 1'b0, 2, 32'h20);
        wrq.push_back('{32'h24, 4'b1111, 32'hDEAD_BEEF});
        issue(1'b1, 2'd2, 1'b0, 32'h24, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 32'h24);
        issue(1'b0, 2'd0, 1'b0, 32'h27, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, 32'h24);
        issue(1'b0, 2'd1, 1'b1, 32'h24, 32'h0, 32'h0000_BEEF, 1'b0, 2, 32'h24);

        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 32'h0);
        issue(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 32'h0);

`ifdef MISALIGN_EN
        issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'hAA99_8877, 1'b0, 3, 32'h10);
        wrq.push_back('{32'h10, 4'b1000, 32'h3400_0000});
        wrq.push_back('{32'h14, 4'b0001, 32'h0000_0012});
        issue(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_1234, 32'h0, 1'b0, 3, 32'h10);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h3477_6655, 1'b0, 2, 32'h10);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'hCCBB_AA12, 1'b0, 2, 32'h14);

        // Crossing store abandoned by reset during its second word.
        wrq.push_back('{32'h10, 4'b1000, 32'hB600_0000});
        @(negedge clk);
        check("abandon_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h13; req_wdata = 32'h0000_A5B6;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abandon_we", {28'd0, we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hB677_6655, 1'b0, 2, 32'h10);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'hCCBB_AA12, 1'b0, 2, 32'h14);
`else
        issue(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_1234, 32'h0, 1'b1, 1, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8877_6655, 1'b0, 2, 32'h10);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'hCCBB_AA99, 1'b0, 2, 32'h14);
`endif

        repeat (3) @(negedge clk);
        if (wrq.size() != 0) check("missing_writes", wrq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
